pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline. It decides each cycle whether PC, IF_ID and ID_EX advance, hold, bubble or flush. Inputs are the load-use hazard, the branch resolved in ID, and the data-cache request/acknowledge handshake of the MEM stage. It produces the global mem_stall_i freeze consumed by ID_EX and the other pipeline registers, and keeps stall statistics plus a miss-timeout flag.

---
 rtl/pipe_pkg.sv | 8 +
 rtl/pipe_hazard_ctrl_if.sv | 31 +++
 rtl/pipe_hazard_ctrl_stall_counter.sv | 23 ++
 rtl/pipe_hazard_ctrl.sv | 94 +++++++++
 tb/tb_pipe_hazard_ctrl.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared widths and FSM encoding for the pipeline hazard/stall sequencer.
package pipe_pkg;
    localparam int PKG_REG_W = 5;
    localparam int PKG_CNT_W = 32;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard inputs from ID/EX/MEM and the stall/flush controls returned to the pipeline.
interface pipe_hazard_ctrl_if
    import pipe_pkg::*;
#(
    parameter int REG_W = PKG_REG_W
);
    logic             id_ex_memread_i;
    logic [REG_W-1:0] id_ex_rt_i;
    logic [REG_W-1:0] if_id_rs_i;
    logic [REG_W-1:0] if_id_rt_i;
    logic             branch_taken_i;
    logic             mem_req_i;
    logic             mem_ack_i;
    logic             pc_write_o;
    logic             if_id_write_o;
    logic             if_id_flush_o;
    logic             id_ex_bubble_o;
    logic             mem_stall_o;

    modport master (
        output id_ex_memread_i, id_ex_rt_i, if_id_rs_i, if_id_rt_i,
               branch_taken_i, mem_req_i, mem_ack_i,
        input  pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o, mem_stall_o
    );

    modport slave (
        input  id_ex_memread_i, id_ex_rt_i, if_id_rs_i, if_id_rt_i,
               branch_taken_i, mem_req_i, mem_ack_i,
        output pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o, mem_stall_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl_stall_counter.sv
// Free-running enable counter, wraps modulo 2^CNT_W, cleared by reset.
module stall_counter
    import pipe_pkg::*;
#(
    parameter int CNT_W = PKG_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer: dcache miss freeze, load-use bubble, branch flush,
// plus stall statistics and a sticky miss-timeout flag.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_W   = PKG_REG_W,
    parameter int CNT_W   = PKG_CNT_W,
    parameter int TIMEOUT = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    pipe_hazard_ctrl_if.slave  hz,
    output logic [CNT_W-1:0]   stall_cnt_o,
    output logic [CNT_W-1:0]   bubble_cnt_o,
    output logic               timeout_err_o
);
    localparam int               WAIT_W       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] TIMEOUT_LAST = WAIT_W'(TIMEOUT - 1);

    logic [0:0]        state_reg, state_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic              timeout_reg, timeout_next;
    logic              mem_stall;
    logic              load_use;

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        timeout_next  = timeout_reg;
        mem_stall     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // A same-cycle ack is a hit and never freezes the pipeline.
                mem_stall     = hz.mem_req_i & ~hz.mem_ack_i;
                wait_cnt_next = '0;
                if (mem_stall) begin
                    state_next = ST_WAIT;
                end
            end
            default: begin
                mem_stall = ~hz.mem_ack_i;
                if (hz.mem_ack_i) begin
                    state_next    = ST_IDLE;
                    wait_cnt_next = '0;
                end else if (wait_cnt_reg == TIMEOUT_LAST) begin
                    // Flag only; the access keeps waiting for the cache.
                    timeout_next = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            timeout_reg  <= timeout_next;
        end
    end

    assign load_use = hz.id_ex_memread_i & (hz.id_ex_rt_i != '0) &
                      ((hz.id_ex_rt_i == hz.if_id_rs_i) | (hz.id_ex_rt_i == hz.if_id_rt_i));

    // Priority: dcache freeze, then load-use bubble, then taken-branch flush.
    assign hz.mem_stall_o    = mem_stall;
    assign hz.pc_write_o     = ~(mem_stall | load_use);
    assign hz.if_id_write_o  = ~(mem_stall | load_use);
    assign hz.id_ex_bubble_o = ~mem_stall & load_use;
    assign hz.if_id_flush_o  = ~mem_stall & ~load_use & hz.branch_taken_i;
    assign timeout_err_o     = timeout_reg;

    logic [1:0]       cnt_en;
    logic [CNT_W-1:0] cnt_val [2];

    assign cnt_en = {~mem_stall & load_use, mem_stall};

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        stall_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (cnt_en[gi]),
            .count (cnt_val[gi])
        );
    end

    assign stall_cnt_o  = cnt_val[0];
    assign bubble_cnt_o = cnt_val[1];
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomised and directed bench for pipe_hazard_ctrl against a cycle-level reference model.
module tb_pipe_hazard_ctrl;
    localparam int REG_W   = 5;
    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_W(REG_W)) hz ();
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] bubble_cnt;
    logic             timeout_err;

    pipe_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .hz            (hz),
        .stall_cnt_o   (stall_cnt),
        .bubble_cnt_o  (bubble_cnt),
        .timeout_err_o (timeout_err)
    );

    // Reference model: "in a miss" flag, consecutive un-acked miss cycles, plain counts.
    bit m_miss;
    int m_waits;
    int m_stall_cnt;
    int m_bubble_cnt;
    bit m_err;
    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic set_in(input bit memread, input int ex_rt, input int id_rs, input int id_rt,
                          input bit br, input bit req, input bit ack);
        hz.id_ex_memread_i = memread;
        hz.id_ex_rt_i      = REG_W'(ex_rt);
        hz.if_id_rs_i      = REG_W'(id_rs);
        hz.if_id_rt_i      = REG_W'(id_rt);
        hz.branch_taken_i  = br;
        hz.mem_req_i       = req;
        hz.mem_ack_i       = ack;
    endtask

    task automatic model_reset();
        m_miss = 0; m_waits = 0; m_stall_cnt = 0; m_bubble_cnt = 0; m_err = 0;
    endtask

    task automatic check_regs(input string pfx);
        check({pfx, "_stall_cnt"},  32'(stall_cnt),   32'(m_stall_cnt  % (1 << CNT_W)));
        check({pfx, "_bubble_cnt"}, 32'(bubble_cnt),  32'(m_bubble_cnt % (1 << CNT_W)));
        check({pfx, "_timeout"},    32'(timeout_err), 32'(m_err));
    endtask

    // Called at posedge+1; asynchronous reset pulse released well before the next negedge.
    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #2;
        check_regs("rst");
        check("rst_stall", 32'(hz.mem_stall_o), 32'(hz.mem_req_i & ~hz.mem_ack_i));
        rst_n = 1'b1;
    endtask

    // One clock: compare everything at the negedge, then advance the model at the posedge.
    task automatic run_cycle();
        bit req, ack, br, lu, e_stall, e_pc, e_bub, e_flush;
        @(negedge clk);
        req = hz.mem_req_i;
        ack = hz.mem_ack_i;
        br  = hz.branch_taken_i;
        lu  = hz.id_ex_memread_i && (hz.id_ex_rt_i != 0) &&
              (hz.id_ex_rt_i == hz.if_id_rs_i || hz.id_ex_rt_i == hz.if_id_rt_i);
        e_stall = m_miss ? !ack : (req && !ack);
        e_pc    = !e_stall && !lu;
        e_bub   = !e_stall && lu;
        e_flush = !e_stall && !lu && br;
        check("mem_stall",   32'(hz.mem_stall_o),    32'(e_stall));
        check("pc_write",    32'(hz.pc_write_o),     32'(e_pc));
        check("if_id_write", 32'(hz.if_id_write_o),  32'(e_pc));
        check("bubble",      32'(hz.id_ex_bubble_o), 32'(e_bub));
        check("flush",       32'(hz.if_id_flush_o),  32'(e_flush));
        check_regs("cyc");
        $display("cyc %0d req=%b ack=%b lu=%b br=%b | stall=%b pc=%b bub=%b fl=%b scnt=%0d bcnt=%0d err=%b",
                 cyc, req, ack, lu, br, hz.mem_stall_o, hz.pc_write_o, hz.id_ex_bubble_o,
                 hz.if_id_flush_o, stall_cnt, bubble_cnt, timeout_err);
        @(posedge clk);
        if (e_stall) m_stall_cnt++;
        if (e_bub)   m_bubble_cnt++;
        if (m_miss) begin
            if (ack) begin
                m_miss = 0;
            end else begin
                m_waits++;
                if (m_waits >= TIMEOUT) m_err = 1;
            end
        end else if (e_stall) begin
            m_miss  = 1;
            m_waits = 0;
        end
        cyc++;
        #1;
    endtask

    initial begin
        set_in(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(posedge clk);
        #1;
        do_reset();
        run_cycle();
        run_cycle();

        // Load-use on rs, then the same with the $zero destination.
        set_in(1, 5, 5, 0, 0, 0, 0);
        run_cycle();
        check("lu_bcnt", 32'(bubble_cnt), 32'd1);
        set_in(1, 0, 0, 0, 0, 0, 0);
        run_cycle();
        check("lu_r0_bcnt", 32'(bubble_cnt), 32'd1);

        // Three-cycle miss followed by ack.
        set_in(0, 0, 0, 0, 0, 1, 0);
        repeat (3) run_cycle();
        set_in(0, 0, 0, 0, 0, 1, 1);
        run_cycle();
        check("miss_scnt", 32'(stall_cnt), 32'd3);
        set_in(0, 0, 0, 0, 0, 0, 0);
        run_cycle();

        // Hit: request and ack together.
        set_in(0, 0, 0, 0, 0, 1, 1);
        repeat (2) run_cycle();
        check("hit_scnt", 32'(stall_cnt), 32'd3);

        // Load-use masks a taken branch; branch flushes the next cycle.
        set_in(1, 7, 0, 7, 1, 0, 0);
        run_cycle();
        set_in(0, 7, 0, 7, 1, 0, 0);
        run_cycle();

        // Timeout after the fourth un-acked WAIT cycle, sticky across ack.
        set_in(0, 0, 0, 0, 0, 1, 0);
        repeat (4) run_cycle();
        check("to_early", 32'(timeout_err), 32'd0);
        run_cycle();
        check("to_set", 32'(timeout_err), 32'd1);
        set_in(0, 0, 0, 0, 0, 1, 1);
        run_cycle();
        check("to_sticky", 32'(timeout_err), 32'd1);

        // Reset in the middle of a miss returns to IDLE.
        set_in(0, 0, 0, 0, 0, 1, 0);
        repeat (2) run_cycle();
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0);
        run_cycle();

        // Randomised traffic with small register indices so hazards are frequent.
        for (int i = 0; i < 300; i++) begin
            set_in(($urandom_range(0, 2) == 0),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 2) == 0),
                   ($urandom_range(0, 2) == 0));
            if ($urandom_range(0, 49) == 0) do_reset();
            run_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
